// File: rtl/bram_arb_ctrl.sv
// bram_arb_ctrl: two-master burst controller and round-robin arbiter in
// front of a single-port synchronous BRAM with a one-cycle registered read.
// One beat is issued per cycle while a burst runs; read data returns one
// cycle after each read beat, tagged by rvalid0/rvalid1.
module bram_arb_ctrl #(
  parameter int W_DATA = 32,
  parameter int W_WORD = 4
) (
  input  logic              clk,
  input  logic              rstn,
  // requester 0
  input  logic              req0,
  input  logic              we0,
  input  logic [W_WORD-1:0] addr0,
  input  logic [W_WORD-1:0] len0,
  input  logic [W_DATA-1:0] wdata0,
  output logic              gnt0,
  output logic              wready0,
  output logic              rvalid0,
  // requester 1
  input  logic              req1,
  input  logic              we1,
  input  logic [W_WORD-1:0] addr1,
  input  logic [W_WORD-1:0] len1,
  input  logic [W_DATA-1:0] wdata1,
  output logic              gnt1,
  output logic              wready1,
  output logic              rvalid1,
  // shared read return and status
  output logic [W_DATA-1:0] rdata,
  output logic              busy,
  // BRAM port
  output logic              bram_en,
  output logic              bram_we,
  output logic [W_WORD-1:0] bram_addr,
  output logic [W_DATA-1:0] bram_din,
  input  logic [W_DATA-1:0] bram_dout
);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t            state;
  logic              owner;     // 0 = requester 0 owns the burst, 1 = requester 1
  logic              is_wr;     // burst direction captured at grant
  logic              rr_last;   // requester served most recently
  logic [W_WORD-1:0] cur_addr;  // address of the beat issued this cycle
  logic [W_WORD-1:0] beat_cnt;  // beats remaining after the current one

  logic              rd_vld_p1; // a read beat was issued last cycle
  logic              rd_own_p1; // owner of that read beat

  logic              win_any;
  logic              win_sel;
  logic              win_we;
  logic [W_WORD-1:0] win_addr;
  logic [W_WORD-1:0] win_len;

  // Round-robin choice: a lone requester always wins; on a tie the one not
  // served last wins.
  function automatic logic pick_winner(input logic r0, input logic r1,
                                       input logic last);
    if (r0 && r1) begin
      return ~last;
    end
    return r1;
  endfunction

  // Next beat address, wrapping modulo the memory depth.
  function automatic logic [W_WORD-1:0] next_addr(input logic [W_WORD-1:0] a);
    return a + W_WORD'(1);
  endfunction

  // Winner selection and mux of its command fields.
  always_comb begin
    win_any  = req0 | req1;
    win_sel  = pick_winner(req0, req1, rr_last);
    win_we   = win_sel ? we1   : we0;
    win_addr = win_sel ? addr1 : addr0;
    win_len  = win_sel ? len1  : len0;
  end

  // Control FSM: arbitrate in IDLE, step address and beat counter in BURST.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      owner    <= 1'b0;
      is_wr    <= 1'b0;
      rr_last  <= 1'b1;
      cur_addr <= '0;
      beat_cnt <= '0;
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
    end else begin
      gnt0 <= 1'b0;
      gnt1 <= 1'b0;
      if (state == IDLE) begin
        if (win_any) begin
          owner    <= win_sel;
          rr_last  <= win_sel;
          is_wr    <= win_we;
          cur_addr <= win_addr;
          beat_cnt <= win_len;
          gnt0     <= ~win_sel;
          gnt1     <= win_sel;
          state    <= BURST;
        end
      end else begin
        cur_addr <= next_addr(cur_addr);
        beat_cnt <= beat_cnt - W_WORD'(1);
        if (beat_cnt == '0) begin
          state <= IDLE;
        end
      end
    end
  end

  // ---- stage p1: read-return tag, aligned with the BRAM's registered dout
  // Tag each issued read beat so its data can be steered one cycle later.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_vld_p1 <= 1'b0;
      rd_own_p1 <= 1'b0;
    end else begin
      rd_vld_p1 <= (state == BURST) && !is_wr;
      rd_own_p1 <= owner;
    end
  end

  // BRAM drive and per-requester strobes, all quiet outside a burst.
  always_comb begin
    busy      = (state == BURST);
    bram_en   = busy;
    bram_we   = busy & is_wr;
    bram_addr = busy ? cur_addr : '0;
    bram_din  = '0;
    if (busy && is_wr) begin
      bram_din = owner ? wdata1 : wdata0;
    end
    wready0   = busy & is_wr & ~owner;
    wready1   = busy & is_wr & owner;
    rvalid0   = rd_vld_p1 & ~rd_own_p1;
    rvalid1   = rd_vld_p1 & rd_own_p1;
    rdata     = bram_dout;
  end

endmodule

// File: tb/tb_bram_arb_ctrl.sv
// Bench for bram_arb_ctrl: directed scenarios followed by random traffic,
// all checked cycle by cycle against a transaction-level expectation
// timeline built from the arbitration and burst rules.
module tb_bram_arb_ctrl;
  localparam int W_DATA = 32;
  localparam int W_WORD = 4;
  localparam int N_WORD = 1 << W_WORD;
  localparam int MAXC   = 4096;

  logic              clk = 1'b0;
  logic              rstn;
  logic              req0, we0, req1, we1;
  logic [W_WORD-1:0] addr0, len0, addr1, len1;
  logic [W_DATA-1:0] wdata0, wdata1;
  logic              gnt0, gnt1, wready0, wready1, rvalid0, rvalid1;
  logic [W_DATA-1:0] rdata;
  logic              busy, bram_en, bram_we;
  logic [W_WORD-1:0] bram_addr;
  logic [W_DATA-1:0] bram_din;
  logic [W_DATA-1:0] bram_dout;

  always #5 clk = ~clk;

  bram_arb_ctrl #(.W_DATA(W_DATA), .W_WORD(W_WORD)) dut (
    .clk(clk), .rstn(rstn),
    .req0(req0), .we0(we0), .addr0(addr0), .len0(len0), .wdata0(wdata0),
    .gnt0(gnt0), .wready0(wready0), .rvalid0(rvalid0),
    .req1(req1), .we1(we1), .addr1(addr1), .len1(len1), .wdata1(wdata1),
    .gnt1(gnt1), .wready1(wready1), .rvalid1(rvalid1),
    .rdata(rdata), .busy(busy),
    .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
    .bram_din(bram_din), .bram_dout(bram_dout)
  );

  // Single-port BRAM with registered read.
  logic [W_DATA-1:0] mem [N_WORD];
  always @(posedge clk) begin
    if (bram_en) begin
      if (bram_we) mem[bram_addr] <= bram_din;
      else         bram_dout      <= mem[bram_addr];
    end
  end

  // Expected output timeline, indexed by cycle number.
  bit                e_gnt0[MAXC], e_gnt1[MAXC], e_busy[MAXC], e_en[MAXC], e_we[MAXC];
  bit                e_wr0[MAXC], e_wr1[MAXC], e_rv0[MAXC], e_rv1[MAXC], e_rk[MAXC];
  logic [W_WORD-1:0] e_addr[MAXC];
  logic [W_DATA-1:0] e_din[MAXC], e_rdata[MAXC];
  logic [W_DATA-1:0] wd0[MAXC], wd1[MAXC];
  logic [W_DATA-1:0] ref_mem[N_WORD];
  bit                ref_known[N_WORD];

  int cyc, free_from, m_last;
  bit granted0, granted1;
  int total, bad;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_clear(input int from);
    for (int k = from; k < MAXC; k++) begin
      e_gnt0[k] = 0; e_gnt1[k] = 0; e_busy[k] = 0; e_en[k] = 0; e_we[k] = 0;
      e_wr0[k] = 0; e_wr1[k] = 0; e_rv0[k] = 0; e_rv1[k] = 0; e_rk[k] = 0;
      e_addr[k] = '0; e_din[k] = '0; e_rdata[k] = '0;
    end
  endtask

  task automatic model_reset();
    model_clear(cyc);
    m_last    = 1;
    free_from = cyc;
  endtask

  // Called at the clock edge that ends cycle 'cyc': if the controller is free,
  // grant a requester and lay out the whole burst on the timeline.
  task automatic model_edge();
    int w, a, n, k, ad;
    bit wr;
    logic [W_DATA-1:0] d;
    granted0 = 0;
    granted1 = 0;
    if (rstn && cyc >= free_from && (req0 || req1)) begin
      if (req0 && req1) w = 1 - m_last;
      else              w = req1 ? 1 : 0;
      m_last = w;
      wr = (w == 1) ? we1 : we0;
      a  = (w == 1) ? int'(addr1) : int'(addr0);
      n  = ((w == 1) ? int'(len1) : int'(len0)) + 1;
      if (w == 1) begin granted1 = 1; e_gnt1[cyc+1] = 1; end
      else        begin granted0 = 1; e_gnt0[cyc+1] = 1; end
      for (int i = 0; i < n; i++) begin
        k  = cyc + 1 + i;
        ad = (a + i) % N_WORD;
        e_busy[k] = 1; e_en[k] = 1; e_we[k] = wr; e_addr[k] = W_WORD'(ad);
        if (wr) begin
          d = (w == 1) ? wd1[k] : wd0[k];
          e_din[k] = d;
          if (w == 1) e_wr1[k] = 1; else e_wr0[k] = 1;
          ref_mem[ad]   = d;
          ref_known[ad] = 1;
        end else begin
          if (w == 1) e_rv1[k+1] = 1; else e_rv0[k+1] = 1;
          e_rdata[k+1] = ref_mem[ad];
          e_rk[k+1]    = ref_known[ad];
        end
      end
      free_from = cyc + n + 1;
    end
  endtask

  task automatic check_cycle(input int k);
    chk("gnt0",    64'(gnt0),    64'(e_gnt0[k]));
    chk("gnt1",    64'(gnt1),    64'(e_gnt1[k]));
    chk("busy",    64'(busy),    64'(e_busy[k]));
    chk("bram_en", 64'(bram_en), 64'(e_en[k]));
    chk("bram_we", 64'(bram_we), 64'(e_we[k]));
    chk("wready0", 64'(wready0), 64'(e_wr0[k]));
    chk("wready1", 64'(wready1), 64'(e_wr1[k]));
    chk("rvalid0", 64'(rvalid0), 64'(e_rv0[k]));
    chk("rvalid1", 64'(rvalid1), 64'(e_rv1[k]));
    if (e_en[k]) chk("bram_addr", 64'(bram_addr), 64'(e_addr[k]));
    if (e_en[k] && e_we[k]) chk("bram_din", 64'(bram_din), 64'(e_din[k]));
    if ((e_rv0[k] || e_rv1[k]) && e_rk[k]) chk("rdata", 64'(rdata), 64'(e_rdata[k]));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
    wdata0 = wd0[cyc];
    wdata1 = wd1[cyc];
    @(negedge clk);
    check_cycle(cyc);
  endtask

  // Raise a request and hold it until the model grants it (bounded).
  task automatic issue(input int p, input bit w, input int a, input int l);
    bit got;
    got = 0;
    if (p == 0) begin we0 = w; addr0 = W_WORD'(a); len0 = W_WORD'(l); req0 = 1; end
    else        begin we1 = w; addr1 = W_WORD'(a); len1 = W_WORD'(l); req1 = 1; end
    for (int t = 0; t < 40 && !got; t++) begin
      tick();
      got = (p == 0) ? granted0 : granted1;
    end
    if (!got) chk("grant_timeout", 64'(0), 64'(1));
    if (p == 0) req0 = 0; else req1 = 0;
  endtask

  task automatic drain();
    for (int t = 0; t < 40 && cyc <= free_from; t++) tick();
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must drop at once.
  task automatic reset_pulse();
    #2;
    rstn = 0;
    model_reset();
    #1;
    chk("rst_busy",    64'(busy),    64'(0));
    chk("rst_bram_en", 64'(bram_en), 64'(0));
    chk("rst_bram_we", 64'(bram_we), 64'(0));
    chk("rst_rvalid0", 64'(rvalid0), 64'(0));
    chk("rst_rvalid1", 64'(rvalid1), 64'(0));
    chk("rst_gnt",     64'({gnt0, gnt1}), 64'(0));
    chk("rst_wready",  64'({wready0, wready1}), 64'(0));
    chk("rst_addr",    64'(bram_addr), 64'(0));
    tick();
    tick();
    rstn = 1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0; bad = 0; cyc = 0;
    for (int k = 0; k < MAXC; k++) begin
      wd0[k] = $urandom;
      wd1[k] = $urandom;
    end
    for (int a = 0; a < N_WORD; a++) begin
      ref_mem[a] = '0;
      ref_known[a] = 0;
    end
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = '0; addr1 = '0; len0 = '0; len1 = '0;
    wdata0 = wd0[0]; wdata1 = wd1[0];
    rstn = 0;
    model_reset();
    #2;
    tick();
    tick();
    rstn = 1;
    tick();

    // write 4 beats at 2..5, then read them back through requester 1
    issue(0, 1, 2, 3);
    drain();
    issue(1, 0, 2, 3);
    drain();

    // both requesting single beats from reset: grants alternate
    reset_pulse();
    we0 = 1; addr0 = 4'd7; len0 = '0;
    we1 = 0; addr1 = 4'd7; len1 = '0;
    req0 = 1; req1 = 1;
    for (int t = 0; t < 10; t++) tick();
    req0 = 0; req1 = 0;
    drain();

    // full-memory write, requester 1 arriving mid-burst waits for it
    issue(0, 1, 0, 15);
    for (int t = 0; t < 5; t++) tick();
    issue(1, 0, 3, 2);
    drain();

    // read wrapping past the top of memory
    issue(1, 0, 14, 3);
    drain();

    // reset during beat 2 of an 8-beat read; req0 then wins the first tie
    issue(0, 0, 0, 7);
    tick();
    tick();
    reset_pulse();
    we1 = 0; addr1 = 4'd9; len1 = 4'd1; req1 = 1;
    issue(0, 1, 5, 1);
    chk("rst_rr_first", 64'(gnt0), 64'(1));
    for (int t = 0; t < 40 && !granted1; t++) tick();
    req1 = 0;
    drain();

    // random traffic from both masters
    for (int it = 0; it < 1500; it++) begin
      if (!req0 && $urandom_range(0, 3) == 0) begin
        we0   = 1'($urandom_range(0, 1));
        addr0 = W_WORD'($urandom_range(0, N_WORD - 1));
        len0  = ($urandom_range(0, 7) == 0) ? W_WORD'($urandom_range(0, N_WORD - 1))
                                            : W_WORD'($urandom_range(0, 3));
        req0  = 1;
      end
      if (!req1 && $urandom_range(0, 3) == 0) begin
        we1   = 1'($urandom_range(0, 1));
        addr1 = W_WORD'($urandom_range(0, N_WORD - 1));
        len1  = ($urandom_range(0, 7) == 0) ? W_WORD'($urandom_range(0, N_WORD - 1))
                                            : W_WORD'($urandom_range(0, 3));
        req1  = 1;
      end
      tick();
      if (granted0) req0 = 0;
      if (granted1) req1 = 0;
    end
    req0 = 0; req1 = 0;
    drain();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
